mmio_player_mover: RTL and testbench
====================================

MMIO_PLAYER_MOVER -- requirements
Module: mmio_player_mover

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high, with ports named clock and reset.
REQ-002 Parameter INPUT_ADDR, 17'd4100, direction-input port read address.
REQ-003 Parameter X_ADDR, 17'd4200, player x-position port (read/write).
REQ-004 Parameter Y_ADDR, 17'd4201, player y-position port (read/write).
REQ-005 Parameter PWR_ADDR, 17'd4202, powerup status port (read).
REQ-006 Parameter COLL_BASE, 17'd4300, collision port base; up/right/down/left = base+0/1/2/3.
REQ-007 Parameter XMAX, 32'd616, maximum legal x; parameter YMAX, 32'd456, maximum legal y.
REQ-008 clock  input  1  master clock; all state changes on posedge.
REQ-009 reset  input  1  asynchronous, active-high.
REQ-010 tick  input  1  move-request strobe, one cycle wide.
REQ-011 q_in  input  32  read data from the memory-mapped responder.
REQ-012 address_dmem  output  17  bus address, registered.
REQ-013 data  output  32  write data, registered.
REQ-014 wren  output  1  write enable, registered.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at end of each move attempt.
REQ-017 moved  output  1  valid with done; 1 = position written.
REQ-018 overrun  output  1  sticky; set by a tick arriving while busy.

Function
REQ-019 States SHALL be IDLE, RD_IN, RD_PWR, RD_COLL, RD_POS, WR_POS, DONE; each lasts exactly one cycle.
REQ-020 IDLE: address 0, data 0, wren 0; tick=1 moves to RD_IN; no tick stays in IDLE.
REQ-021 Read timing: the address is held for the whole state; q_in is sampled at the posedge that leaves the state (one-cycle read latency; the responder updates on negedge).
REQ-022 RD_IN: address INPUT_ADDR; capture dir=q_in; values 1..4 go to RD_PWR, any other value goes to DONE with moved=0.
REQ-023 RD_PWR: address PWR_ADDR; step=2 if q_in==1, else step=1.
REQ-024 RD_COLL: address COLL_BASE+dir-1; q_in==1 goes to DONE with moved=0; any other value goes to RD_POS.
REQ-025 RD_POS: address Y_ADDR for dir 1/3, X_ADDR for dir 2/4; capture pos=q_in.
REQ-026 New position: dir 1/4 gives pos<step ? 0 : pos-step; dir 2/3 gives min(pos+step, MAX), with MAX=YMAX for y and XMAX for x; 33-bit sum, no wrap.
REQ-027 A pos already above MAX on an increment SHALL be written as MAX.
REQ-028 WR_POS: address equals the RD_POS address, data = new position, wren=1 for exactly this one cycle; then DONE with moved=1.
REQ-029 DONE: done=1, moved valid, bus idle values; next state IDLE unconditionally.
REQ-030 A full move SHALL take 7 cycles from tick to return to IDLE; an input abort 3 cycles; a collision abort 5 cycles.
REQ-031 A tick outside IDLE (including DONE) SHALL be ignored and SHALL set overrun; overrun clears only on reset.
REQ-032 wren SHALL never be high outside WR_POS.

Reset
REQ-033 reset SHALL force IDLE, address_dmem=0, data=0, wren=0, busy=0, done=0, moved=0, overrun=0, and clear dir, step and pos, at any time including mid-transaction.
REQ-034 A write in progress at reset SHALL be dropped; wren falls asynchronously.

Structure
REQ-035 State encodings, direction codes (1..4) and default port addresses SHALL live in shared package pacman_mmio_pkg.
REQ-036 The saturating step arithmetic SHALL be one sub-module, step_saturate (pos, step, dec, max -> new_pos).

Verification
REQ-037 q_in: dir=2, pwr=0, coll=0, x=260; tick -> one write of 261 to 4200 at cycle 5, done with moved=1 at cycle 6.
REQ-038 dir=1, pwr=1, y=1 -> write of 0 to 4201 (saturated low).
REQ-039 dir=3, pwr=1, y=455, YMAX=456 -> write of 456 to 4201.
REQ-040 dir=4, coll at 4303=1 -> no wren, done with moved=0 at cycle 4; dir=0 -> done with moved=0 at cycle 2.
REQ-041 tick again at cycle 3 of a move -> overrun=1, the move completes unchanged, the second tick is not serviced.
REQ-042 reset asserted during WR_POS -> wren=0 immediately; after release, IDLE with all outputs 0.

Source files
------------

// File: rtl/pacman_mmio_pkg.sv
// Shared encodings and default port map for the pacman MMIO player mover.
package pacman_mmio_pkg;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STEP_W = 2;

  localparam logic [ADDR_W-1:0] DEF_INPUT_ADDR = 17'd4100;
  localparam logic [ADDR_W-1:0] DEF_X_ADDR     = 17'd4200;
  localparam logic [ADDR_W-1:0] DEF_Y_ADDR     = 17'd4201;
  localparam logic [ADDR_W-1:0] DEF_PWR_ADDR   = 17'd4202;
  localparam logic [ADDR_W-1:0] DEF_COLL_BASE  = 17'd4300;
  localparam logic [DATA_W-1:0] DEF_XMAX       = 32'd616;
  localparam logic [DATA_W-1:0] DEF_YMAX       = 32'd456;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_IN   = 3'd1,
    S_RD_PWR  = 3'd2,
    S_RD_COLL = 3'd3,
    S_RD_POS  = 3'd4,
    S_WR_POS  = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_LEFT  = 3'd4
  } dir_e;

  function automatic logic dir_valid(input logic [DATA_W-1:0] v);
    return (v >= 32'd1) && (v <= 32'd4);
  endfunction

endpackage

// File: rtl/mmio_player_mover_if.sv
// Memory-mapped bus between the player mover (master) and its responder (slave).
interface mmio_player_mover_if;
  import pacman_mmio_pkg::*;

  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_in;

  modport master (output address_dmem, output data, output wren, input q_in);
  modport slave  (input address_dmem, input data, input wren, output q_in);
endinterface

// File: rtl/mmio_player_mover_step_saturate.sv
// Position step with clamping: decrement floors at 0, increment caps at max.
module step_saturate
  import pacman_mmio_pkg::*;
(
  input  logic [DATA_W-1:0] pos,
  input  logic [STEP_W-1:0] step,
  input  logic              dec,
  input  logic [DATA_W-1:0] max,
  output logic [DATA_W-1:0] new_pos
);

  localparam int unsigned SUM_W = DATA_W + 1;

  logic [DATA_W-1:0] w_step;
  logic [SUM_W-1:0]  w_sum;

  assign w_step = DATA_W'(step);
  assign w_sum  = SUM_W'(pos) + SUM_W'(step);

  // A position already beyond max also lands on max.
  always_comb begin
    new_pos = '0;
    if (dec) begin
      new_pos = (pos < w_step) ? '0 : (pos - w_step);
    end else begin
      new_pos = (w_sum > SUM_W'(max)) ? max : w_sum[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/mmio_player_mover.sv
// Reads direction, powerup and collision ports, then writes the stepped player
// position back over the MMIO bus, one move attempt per tick.
module mmio_player_mover
  import pacman_mmio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] INPUT_ADDR = DEF_INPUT_ADDR,
  parameter logic [ADDR_W-1:0] X_ADDR     = DEF_X_ADDR,
  parameter logic [ADDR_W-1:0] Y_ADDR     = DEF_Y_ADDR,
  parameter logic [ADDR_W-1:0] PWR_ADDR   = DEF_PWR_ADDR,
  parameter logic [ADDR_W-1:0] COLL_BASE  = DEF_COLL_BASE,
  parameter logic [DATA_W-1:0] XMAX       = DEF_XMAX,
  parameter logic [DATA_W-1:0] YMAX       = DEF_YMAX
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  mmio_player_mover_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                moved,
  output logic                overrun
);

  state_e            r_state, w_state_nxt;
  dir_e              r_dir, w_dir_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic [DATA_W-1:0] r_pos, w_pos_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_wren, w_wren_nxt;
  logic              r_busy, r_done, r_moved, w_moved_nxt, r_overrun;

  logic              w_dec, w_is_y;
  logic [DATA_W-1:0] w_max, w_new_pos;
  logic [ADDR_W-1:0] w_coll_addr, w_pos_addr;

  assign w_dec       = (r_dir == DIR_UP) || (r_dir == DIR_LEFT);
  assign w_is_y      = (r_dir == DIR_UP) || (r_dir == DIR_DOWN);
  assign w_max       = w_is_y ? YMAX : XMAX;
  assign w_coll_addr = COLL_BASE + ADDR_W'(r_dir) - 17'd1;
  assign w_pos_addr  = w_is_y ? Y_ADDR : X_ADDR;
  // Position is consumed live at the end of RD_POS so WR_POS can present it.
  assign w_pos_nxt   = (r_state == S_RD_POS) ? bus.q_in : r_pos;

  step_saturate u_step (
    .pos     (w_pos_nxt),
    .step    (r_step),
    .dec     (w_dec),
    .max     (w_max),
    .new_pos (w_new_pos)
  );

  // Next state plus next-cycle bus values, so outputs line up with their state.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_step_nxt  = r_step;
    w_addr_nxt  = '0;
    w_data_nxt  = '0;
    w_wren_nxt  = 1'b0;
    w_moved_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tick) begin
          w_state_nxt = S_RD_IN;
          w_addr_nxt  = INPUT_ADDR;
        end
      end
      S_RD_IN: begin
        if (dir_valid(bus.q_in)) begin
          w_dir_nxt   = dir_e'(bus.q_in[2:0]);
          w_state_nxt = S_RD_PWR;
          w_addr_nxt  = PWR_ADDR;
        end else begin
          w_dir_nxt   = DIR_NONE;
          w_state_nxt = S_DONE;
        end
      end
      S_RD_PWR: begin
        w_step_nxt  = (bus.q_in == 32'd1) ? 2'd2 : 2'd1;
        w_state_nxt = S_RD_COLL;
        w_addr_nxt  = w_coll_addr;
      end
      S_RD_COLL: begin
        if (bus.q_in == 32'd1) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RD_POS;
          w_addr_nxt  = w_pos_addr;
        end
      end
      S_RD_POS: begin
        w_state_nxt = S_WR_POS;
        w_addr_nxt  = r_addr;
        w_data_nxt  = w_new_pos;
        w_wren_nxt  = 1'b1;
      end
      S_WR_POS: begin
        w_state_nxt = S_DONE;
        w_moved_nxt = 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_dir     <= DIR_NONE;
      r_step    <= '0;
      r_pos     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_wren    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_moved   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir     <= w_dir_nxt;
      r_step    <= w_step_nxt;
      r_pos     <= w_pos_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_wren    <= w_wren_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
      r_moved   <= w_moved_nxt;
      r_overrun <= r_overrun | (tick && (r_state != S_IDLE));
    end
  end

  assign bus.address_dmem = r_addr;
  assign bus.data         = r_data;
  assign bus.wren         = r_wren;
  assign busy             = r_busy;
  assign done             = r_done;
  assign moved            = r_moved;
  assign overrun          = r_overrun;

endmodule

// File: tb/tb_mmio_player_mover.sv
// Directed bench for mmio_player_mover: vector table of single moves plus
// hand-written overrun and mid-write reset sequences.
module tb_mmio_player_mover;
  import pacman_mmio_pkg::*;

  logic clock, reset, tick;
  logic busy, done, moved, overrun;

  mmio_player_mover_if bus ();

  mmio_player_mover dut (
    .clock   (clock),
    .reset   (reset),
    .tick    (tick),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .moved   (moved),
    .overrun (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] m_in, m_pwr, m_x, m_y;
  logic [31:0] m_coll [4];

  function automatic logic [31:0] rsp(input logic [16:0] a);
    case (a)
      17'd4100: return m_in;
      17'd4202: return m_pwr;
      17'd4200: return m_x;
      17'd4201: return m_y;
      17'd4300: return m_coll[0];
      17'd4301: return m_coll[1];
      17'd4302: return m_coll[2];
      17'd4303: return m_coll[3];
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Responder: read data follows the address on the falling edge.
  always @(negedge clock) bus.q_in <= rsp(bus.address_dmem);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] dir, pwr, x, y;
    int          coll_idx;
    logic [31:0] coll_val;
    int          exp_nwr;
    logic [16:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_done;
    logic        exp_moved;
    int          exp_idle;
  } vec_t;

  task automatic load(input vec_t v);
    m_in  = v.dir;
    m_pwr = v.pwr;
    m_x   = v.x;
    m_y   = v.y;
    for (int k = 0; k < 4; k++) m_coll[k] = 32'd0;
    m_coll[v.coll_idx] = v.coll_val;
  endtask

  // One tick at cycle 0, optional second tick at cycle retick; samples 12 cycles.
  task automatic run_move(input int retick, output int nwr, output logic [16:0] wa,
                          output logic [31:0] wd, output int wc, output int dc,
                          output logic mv, output int ic, output logic [16:0] ia,
                          output logic [31:0] id, output int late);
    nwr = 0; wa = '0; wd = '0; wc = -1; dc = -1; mv = 1'b0;
    ic = -1; ia = '1; id = '1; late = 0;
    @(negedge clock);
    tick = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      tick = (c == retick);
      if (bus.wren) begin
        nwr++; wa = bus.address_dmem; wd = bus.data; wc = c;
      end
      if (done && dc < 0) begin
        dc = c; mv = moved;
      end
      if (ic >= 0 && busy) late++;
      if (!busy && ic < 0) begin
        ic = c; ia = bus.address_dmem; id = bus.data;
      end
    end
  endtask

  vec_t vecs [13];
  int nwr, wc, dc, ic, late;
  logic [16:0] wa, ia;
  logic [31:0] wd, id;
  logic mv;

  initial begin
    //          dir    pwr    x      y      ci cv   nwr addr  data  done mv idle
    vecs[0]  = '{32'd2, 32'd0, 32'd260, 32'd100, 0, 32'd0, 1, 17'd4200, 32'd261, 6, 1'b1, 7};
    vecs[1]  = '{32'd1, 32'd1, 32'd50,  32'd1,   0, 32'd0, 1, 17'd4201, 32'd0,   6, 1'b1, 7};
    vecs[2]  = '{32'd3, 32'd1, 32'd50,  32'd455, 0, 32'd0, 1, 17'd4201, 32'd456, 6, 1'b1, 7};
    vecs[3]  = '{32'd4, 32'd0, 32'd100, 32'd100, 3, 32'd1, 0, 17'd0,    32'd0,   4, 1'b0, 5};
    vecs[4]  = '{32'd0, 32'd0, 32'd100, 32'd100, 0, 32'd0, 0, 17'd0,    32'd0,   2, 1'b0, 3};
    vecs[5]  = '{32'd4, 32'd0, 32'd0,   32'd100, 0, 32'd0, 1, 17'd4200, 32'd0,   6, 1'b1, 7};
    vecs[6]  = '{32'd2, 32'd1, 32'd700, 32'd100, 0, 32'd0, 1, 17'd4200, 32'd616, 6, 1'b1, 7};
    vecs[7]  = '{32'd1, 32'd0, 32'd5,   32'd10,  0, 32'd0, 1, 17'd4201, 32'd9,   6, 1'b1, 7};
    vecs[8]  = '{32'd5, 32'd0, 32'd5,   32'd10,  0, 32'd0, 0, 17'd0,    32'd0,   2, 1'b0, 3};
    vecs[9]  = '{32'd2, 32'd1, 32'd614, 32'd10,  0, 32'd1, 1, 17'd4200, 32'd616, 6, 1'b1, 7};
    vecs[10] = '{32'd3, 32'd0, 32'd5,   32'd0,   2, 32'd2, 1, 17'd4201, 32'd1,   6, 1'b1, 7};
    vecs[11] = '{32'h102, 32'd0, 32'd5, 32'd10,  0, 32'd0, 0, 17'd0,    32'd0,   2, 1'b0, 3};
    vecs[12] = '{32'd2, 32'd2, 32'd5,   32'd10,  0, 32'd0, 1, 17'd4200, 32'd6,   6, 1'b1, 7};

    tick  = 1'b0;
    reset = 1'b1;
    load(vecs[0]);
    repeat (2) @(negedge clock);
    check("rst_addr",    64'(bus.address_dmem), 64'd0);
    check("rst_data",    64'(bus.data),         64'd0);
    check("rst_wren",    64'(bus.wren),         64'd0);
    check("rst_busy",    64'(busy),             64'd0);
    check("rst_done",    64'(done),             64'd0);
    check("rst_moved",   64'(moved),            64'd0);
    check("rst_overrun", 64'(overrun),          64'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 13; i++) begin
      load(vecs[i]);
      run_move(0, nwr, wa, wd, wc, dc, mv, ic, ia, id, late);
      check($sformatf("v%0d_nwr", i), 64'(nwr), 64'(vecs[i].exp_nwr));
      if (vecs[i].exp_nwr > 0) begin
        check($sformatf("v%0d_waddr", i), 64'(wa), 64'(vecs[i].exp_addr));
        check($sformatf("v%0d_wdata", i), 64'(wd), 64'(vecs[i].exp_data));
        check($sformatf("v%0d_wcyc", i),  64'(wc), 64'd5);
      end
      check($sformatf("v%0d_done_cyc", i), 64'(dc), 64'(vecs[i].exp_done));
      check($sformatf("v%0d_moved", i),    64'(mv), 64'(vecs[i].exp_moved));
      check($sformatf("v%0d_idle_cyc", i), 64'(ic), 64'(vecs[i].exp_idle));
      check($sformatf("v%0d_idle_addr", i), 64'(ia), 64'd0);
      check($sformatf("v%0d_idle_data", i), 64'(id), 64'd0);
      check($sformatf("v%0d_late_busy", i), 64'(late), 64'd0);
    end
    check("no_overrun_yet", 64'(overrun), 64'd0);

    // Second tick during RD_COLL is flagged but not serviced.
    load(vecs[0]);
    run_move(3, nwr, wa, wd, wc, dc, mv, ic, ia, id, late);
    check("ovr_flag",  64'(overrun), 64'd1);
    check("ovr_nwr",   64'(nwr),     64'd1);
    check("ovr_wdata", 64'(wd),      64'd261);
    check("ovr_wcyc",  64'(wc),      64'd5);
    check("ovr_done",  64'(dc),      64'd6);
    check("ovr_idle",  64'(ic),      64'd7);
    check("ovr_late",  64'(late),    64'd0);

    // Tick on the DONE cycle also counts as an overrun; flag stays sticky.
    run_move(6, nwr, wa, wd, wc, dc, mv, ic, ia, id, late);
    check("ovr_done_nwr",  64'(nwr),     64'd1);
    check("ovr_done_late", 64'(late),    64'd0);
    check("ovr_sticky",    64'(overrun), 64'd1);

    // Reset landing in WR_POS drops the write immediately.
    load(vecs[0]);
    @(negedge clock);
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    repeat (4) @(negedge clock);
    check("pre_rst_wren", 64'(bus.wren), 64'd1);
    reset = 1'b1;
    #1;
    check("async_wren", 64'(bus.wren),         64'd0);
    check("async_addr", 64'(bus.address_dmem), 64'd0);
    check("async_busy", 64'(busy),             64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_addr",    64'(bus.address_dmem), 64'd0);
    check("post_rst_data",    64'(bus.data),         64'd0);
    check("post_rst_wren",    64'(bus.wren),         64'd0);
    check("post_rst_busy",    64'(busy),             64'd0);
    check("post_rst_done",    64'(done),             64'd0);
    check("post_rst_moved",   64'(moved),            64'd0);
    check("post_rst_overrun", 64'(overrun),          64'd0);

    load(vecs[2]);
    run_move(0, nwr, wa, wd, wc, dc, mv, ic, ia, id, late);
    check("recover_wdata", 64'(wd), 64'd456);
    check("recover_waddr", 64'(wa), 64'd4201);
    check("recover_done",  64'(dc), 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
